// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single pipelined main memory between I-cache refills, D-cache
// refills and D-cache write-through stores; steers returning words to the right cache.
module cache_fill_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IMissReq,
    input  logic [ADDR_WIDTH-1:0] IMissAddr,
    input  logic                  DMissReq,
    input  logic [ADDR_WIDTH-1:0] DMissAddr,
    input  logic                  DWriteReq,
    input  logic [ADDR_WIDTH-1:0] DWriteAddr,
    input  logic [15:0]           DWriteData,
    input  logic                  MemDataValid,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemEnable,
    output logic                  MemWr,
    output logic [15:0]           MemDataOut,
    output logic [ADDR_WIDTH-1:0] FillWordAddr,
    output logic                  ICacheFillWe,
    output logic                  DCacheFillWe,
    output logic                  IFillDone,
    output logic                  DFillDone,
    output logic                  DWriteDone
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((2 * WORDS_PER_BLOCK) - 1);
    localparam logic [CNT_W:0]        ISSUE_END = (CNT_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    // Memory latency only shapes the external return timing; it must still be sane.
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0
        || MEM_LATENCY < 1) begin : g_bad_param
        $error("cache_fill_arbiter: invalid WORDS_PER_BLOCK or MEM_LATENCY");
    end

    typedef enum logic [1:0] {
        IDLE,
        FILL_I,
        FILL_D,
        WRITE_D
    } state_t;

    state_t                state_q, state_n;
    logic [CNT_W:0]        ic_q, ic_n;
    logic [CNT_W-1:0]      rc_q, rc_n;
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
    logic [15:0]           wdata_q, wdata_n;
    logic                  idone_q, idone_n;
    logic                  ddone_q, ddone_n;
    logic                  wdone_q, wdone_n;

    function automatic logic [ADDR_WIDTH-1:0] word_off(input logic [CNT_W-1:0] w);
        return ADDR_WIDTH'({w, 1'b0});
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            base_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_n;
            ic_q    <= ic_n;
            rc_q    <= rc_n;
            base_q  <= base_n;
            waddr_q <= waddr_n;
            wdata_q <= wdata_n;
            idone_q <= idone_n;
            ddone_q <= ddone_n;
            wdone_q <= wdone_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        ic_n         = ic_q;
        rc_n         = rc_q;
        base_n       = base_q;
        waddr_n      = waddr_q;
        wdata_n      = wdata_q;
        idone_n      = 1'b0;
        ddone_n      = 1'b0;
        wdone_n      = 1'b0;
        MemAddr      = '0;
        MemEnable    = 1'b0;
        MemWr        = 1'b0;
        MemDataOut   = '0;
        FillWordAddr = '0;
        ICacheFillWe = 1'b0;
        DCacheFillWe = 1'b0;

        case (state_q)
            IDLE: begin
                if (DWriteReq) begin
                    state_n = WRITE_D;
                    waddr_n = DWriteAddr;
                    wdata_n = DWriteData;
                end else if (DMissReq) begin
                    state_n = FILL_D;
                    base_n  = DMissAddr & ~OFF_MASK;
                    ic_n    = '0;
                    rc_n    = '0;
                end else if (IMissReq) begin
                    state_n = FILL_I;
                    base_n  = IMissAddr & ~OFF_MASK;
                    ic_n    = '0;
                    rc_n    = '0;
                end
            end

            FILL_I, FILL_D: begin
                // Issue and return run independently: reads stream out while
                // earlier words are still in flight.
                if (ic_q < ISSUE_END) begin
                    MemEnable = 1'b1;
                    MemAddr   = base_q + word_off(ic_q[CNT_W-1:0]);
                    ic_n      = ic_q + (CNT_W + 1)'(1);
                end
                if (MemDataValid) begin
                    FillWordAddr = base_q + word_off(rc_q);
                    ICacheFillWe = (state_q == FILL_I);
                    DCacheFillWe = (state_q == FILL_D);
                    rc_n         = rc_q + CNT_W'(1);
                    if (rc_q == LAST_WORD) begin
                        state_n = IDLE;
                        idone_n = (state_q == FILL_I);
                        ddone_n = (state_q == FILL_D);
                    end
                end
            end

            WRITE_D: begin
                MemEnable  = 1'b1;
                MemWr      = 1'b1;
                MemAddr    = waddr_q;
                MemDataOut = wdata_q;
                state_n    = IDLE;
                wdone_n    = 1'b1;
            end

            default: state_n = IDLE;
        endcase
    end

    assign IFillDone  = idone_q;
    assign DFillDone  = ddone_q;
    assign DWriteDone = wdone_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model and a fixed-latency memory.
module tb_cache_fill_arbiter;

    localparam int LAT = 4;
    localparam int WPB = 8;
    localparam int AW  = 16;

    localparam int K_NONE = 0;
    localparam int K_I    = 1;
    localparam int K_D    = 2;
    localparam int K_W    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          IMissReq, DMissReq, DWriteReq, MemDataValid;
    logic [AW-1:0] IMissAddr, DMissAddr, DWriteAddr;
    logic [15:0]   DWriteData;
    logic [AW-1:0] MemAddr, FillWordAddr;
    logic          MemEnable, MemWr, ICacheFillWe, DCacheFillWe;
    logic [15:0]   MemDataOut;
    logic          IFillDone, DFillDone, DWriteDone;

    always #5 clk = ~clk;

    cache_fill_arbiter #(
        .MEM_LATENCY    (LAT),
        .WORDS_PER_BLOCK(WPB),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IMissReq    (IMissReq),
        .IMissAddr   (IMissAddr),
        .DMissReq    (DMissReq),
        .DMissAddr   (DMissAddr),
        .DWriteReq   (DWriteReq),
        .DWriteAddr  (DWriteAddr),
        .DWriteData  (DWriteData),
        .MemDataValid(MemDataValid),
        .MemAddr     (MemAddr),
        .MemEnable   (MemEnable),
        .MemWr       (MemWr),
        .MemDataOut  (MemDataOut),
        .FillWordAddr(FillWordAddr),
        .ICacheFillWe(ICacheFillWe),
        .DCacheFillWe(DCacheFillWe),
        .IFillDone   (IFillDone),
        .DFillDone   (DFillDone),
        .DWriteDone  (DWriteDone)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Transaction-level reference: what is in progress, how old it is, how many words back.
    int          m_kind  = K_NONE;
    int          m_age   = 0;
    int          m_nval  = 0;
    int          m_entry = 0;
    int          m_done  = K_NONE;
    logic [15:0] m_base  = '0;
    logic [15:0] m_waddr = '0;
    logic [15:0] m_wdata = '0;

    bit [LAT-1:0] pipe = '0;
    bit spur_en = 0;
    bit i_hold  = 0;
    bit d_hold  = 0;
    int i_cnt = 0, d_cnt = 0, w_cnt = 0, iwe_cnt = 0;
    int last_done = K_NONE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_MemAddr"}, MemAddr, 0);
        chk({tag, "_MemEnable"}, MemEnable, 0);
        chk({tag, "_MemWr"}, MemWr, 0);
        chk({tag, "_MemDataOut"}, MemDataOut, 0);
        chk({tag, "_FillWordAddr"}, FillWordAddr, 0);
        chk({tag, "_IWe"}, ICacheFillWe, 0);
        chk({tag, "_DWe"}, DCacheFillWe, 0);
        chk({tag, "_IDone"}, IFillDone, 0);
        chk({tag, "_DDone"}, DFillDone, 0);
        chk({tag, "_WDone"}, DWriteDone, 0);
    endtask

    task automatic check_cycle();
        bit fill, exp_en;
        fill   = (m_kind == K_I) || (m_kind == K_D);
        exp_en = (m_kind == K_W) || (fill && m_age < WPB);
        chk("MemEnable", MemEnable, exp_en);
        chk("MemWr", MemWr, m_kind == K_W);
        if (m_kind == K_W)         chk("MemAddr_wr", MemAddr, m_waddr);
        else if (exp_en)           chk("MemAddr_rd", MemAddr, m_base + 16'(2 * m_age));
        else if (m_kind == K_NONE) chk("MemAddr_idle", MemAddr, 0);
        chk("MemDataOut", MemDataOut, (m_kind == K_W) ? m_wdata : 16'h0);
        chk("ICacheFillWe", ICacheFillWe, (m_kind == K_I) && MemDataValid);
        chk("DCacheFillWe", DCacheFillWe, (m_kind == K_D) && MemDataValid);
        if (fill && MemDataValid) chk("FillWordAddr", FillWordAddr, m_base + 16'(2 * m_nval));
        chk("IFillDone", IFillDone, m_done == K_I);
        chk("DFillDone", DFillDone, m_done == K_D);
        chk("DWriteDone", DWriteDone, m_done == K_W);
    endtask

    // Requesters drop their request in the cycle they see done, unless told to hold.
    task automatic react();
        last_done = IFillDone ? K_I : DFillDone ? K_D : DWriteDone ? K_W : K_NONE;
        i_cnt   += int'(IFillDone);
        d_cnt   += int'(DFillDone);
        w_cnt   += int'(DWriteDone);
        iwe_cnt += int'(ICacheFillWe);
        if (IFillDone && !i_hold) IMissReq = 1'b0;
        if (DFillDone && !d_hold) DMissReq = 1'b0;
        if (DWriteDone) DWriteReq = 1'b0;
    endtask

    task automatic advance();
        bit issued;
        issued = MemEnable && !MemWr;
        m_done = K_NONE;
        if (!rst) begin
            m_kind = K_NONE;
        end else if (m_kind == K_NONE) begin
            if (DWriteReq) begin
                m_kind = K_W; m_waddr = DWriteAddr; m_wdata = DWriteData;
            end else if (DMissReq || IMissReq) begin
                m_kind  = DMissReq ? K_D : K_I;
                m_base  = (DMissReq ? DMissAddr : IMissAddr) & 16'hFFF0;
                m_age   = 0;
                m_nval  = 0;
                m_entry = cyc + 1;
            end
        end else if (m_kind == K_W) begin
            m_done = K_W;
            m_kind = K_NONE;
        end else begin
            m_age++;
            if (MemDataValid) begin
                m_nval++;
                if (m_nval == WPB) begin
                    chk("FillLatency", cyc + 1 - m_entry, WPB + LAT);
                    m_done = m_kind;
                    m_kind = K_NONE;
                end
            end
        end
        pipe = {pipe[LAT-2:0], issued};
    endtask

    task automatic step_body();
        check_cycle();
        react();
        advance();
        @(posedge clk);
        cyc++;
        #2;
        MemDataValid = pipe[LAT-1] |
                       (spur_en && rst && m_kind == K_NONE && $urandom_range(3) == 0);
    endtask

    task automatic step();
        #2;
        step_body();
    endtask

    task automatic run_until(input int kind, input int budget, input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            seen = (last_done == kind);
        end
        chk({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        rst = 1'b0;
        IMissReq = 0; DMissReq = 0; DWriteReq = 0; MemDataValid = 0;
        IMissAddr = '0; DMissAddr = '0; DWriteAddr = '0; DWriteData = '0;
        @(posedge clk);
        #2;
        chk_zero("reset");
        step();
        step();
        rst = 1'b1;
        step();

        // Single I miss, unaligned address inside the block.
        i_cnt = 0; iwe_cnt = 0;
        IMissReq = 1; IMissAddr = 16'h1236;
        run_until(K_I, 40, "single_i");
        repeat (4) step();
        chk("single_i_done_count", i_cnt, 1);
        chk("single_i_we_count", iwe_cnt, WPB);

        // Simultaneous D and I misses: D wins.
        i_cnt = 0; d_cnt = 0;
        DMissReq = 1; DMissAddr = 16'h4000;
        IMissReq = 1; IMissAddr = 16'h0010;
        run_until(K_D, 40, "dual_d");
        chk("dual_i_not_before_d", i_cnt, 0);
        run_until(K_I, 40, "dual_i");
        chk("dual_d_count", d_cnt, 1);

        // Store ahead of a pending D miss.
        w_cnt = 0; d_cnt = 0;
        DWriteReq = 1; DWriteAddr = 16'h2002; DWriteData = 16'hBEEF;
        DMissReq = 1; DMissAddr = 16'h3456;
        run_until(K_W, 10, "write");
        chk("write_before_dfill", d_cnt, 0);
        run_until(K_D, 40, "write_then_d");
        chk("write_count", w_cnt, 1);

        // Reset after the third returned word.
        iwe_cnt = 0; i_cnt = 0;
        IMissReq = 1; IMissAddr = 16'h0A40;
        for (int n = 0; n < 30 && iwe_cnt < 3; n++) step();
        chk("rst_third_word", iwe_cnt, 3);
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        m_kind = K_NONE;
        m_done = K_NONE;
        #1;
        step_body();
        repeat (5) step();
        rst = 1'b1;
        chk("rst_no_done", i_cnt, 0);
        run_until(K_I, 40, "after_reset");

        // Spurious valid in idle.
        repeat (2) step();
        MemDataValid = 1'b1;
        step();
        MemDataValid = 1'b1;
        step();

        // Address wander during a fill.
        IMissReq = 1; IMissAddr = 16'h5550;
        repeat (3) step();
        IMissAddr = 16'hFFFE;
        run_until(K_I, 40, "addr_wander");

        // Back-to-back: request held across done.
        repeat (2) step();
        i_hold = 1;
        IMissReq = 1; IMissAddr = 16'h0100;
        run_until(K_I, 40, "b2b_first");
        i_hold = 0;
        #2;
        chk("b2b_restart_enable", MemEnable, 1);
        chk("b2b_restart_addr", MemAddr, 16'h0100);
        step_body();
        run_until(K_I, 40, "b2b_second");

        // Random traffic.
        spur_en = 1;
        for (int n = 0; n < 800; n++) begin
            if (!IMissReq && $urandom_range(7) == 0) begin
                IMissReq = 1; IMissAddr = 16'($urandom);
            end else if (IMissReq && $urandom_range(15) == 0) begin
                IMissAddr = 16'($urandom);
            end
            if (!DMissReq && $urandom_range(7) == 0) begin
                DMissReq = 1; DMissAddr = 16'($urandom);
            end else if (DMissReq && $urandom_range(15) == 0) begin
                DMissAddr = 16'($urandom);
            end
            if (!DWriteReq && $urandom_range(9) == 0) begin
                DWriteReq = 1; DWriteAddr = 16'($urandom); DWriteData = 16'($urandom);
            end
            if (m_kind == K_I && IMissReq && $urandom_range(31) == 0) IMissReq = 0;
            i_hold = ($urandom_range(3) == 0);
            d_hold = ($urandom_range(3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
